// File: rtl/pcbc_chain_ctrl.sv
// pcbc_chain_ctrl: PCBC chaining controller wrapped around an external AES core.
// One block in flight; the chaining IV advances on each output handshake.
module pcbc_chain_ctrl #(
  parameter int BLK_S   = 128,
  parameter int IV_BITS = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iv_wr,
  input  logic [IV_BITS-1:0] iv_data,
  input  logic               mode_enc,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLK_S-1:0]   in_data,
  input  logic               in_last,
  output logic               aes_start,
  output logic               aes_enc,
  output logic [BLK_S-1:0]   aes_blk_o,
  input  logic               aes_done,
  input  logic [BLK_S-1:0]   aes_blk_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLK_S-1:0]   out_data,
  output logic               out_last,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUTPUT
  } state_e;

  state_e state_q, state_d;

  logic [BLK_S-1:0]   blk_q, blk_d;
  logic [BLK_S-1:0]   in_q, in_d;
  logic [BLK_S-1:0]   out_q, out_d;
  logic [IV_BITS-1:0] base_q, base_d;
  logic [IV_BITS-1:0] chain_q, chain_d;
  logic [IV_BITS-1:0] iv_eff;
  logic               last_q, last_d;
  logic               mode_q, mode_d;
  logic               active_q, active_d;
  logic               iv_load;
  logic               mode_sel;

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    in_d     = in_q;
    out_d    = out_q;
    base_d   = base_q;
    chain_d  = chain_q;
    last_d   = last_q;
    mode_d   = mode_q;
    active_d = active_q;
    iv_load  = iv_wr && !active_q;
    iv_eff   = iv_load ? iv_data : chain_q;
    mode_sel = mode_q;

    unique case (state_q)
      S_IDLE: begin
        if (iv_load) begin
          base_d  = iv_data;
          chain_d = iv_data;
        end
        if (in_valid) begin
          // Mode is frozen for the whole message once its first block is taken.
          mode_sel = active_q ? mode_q : mode_enc;
          mode_d   = mode_sel;
          in_d     = in_data;
          last_d   = in_last;
          blk_d    = mode_sel ? (in_data ^ iv_eff) : in_data;
          active_d = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (aes_done) begin
          out_d   = mode_q ? aes_blk_i : (aes_blk_i ^ chain_q);
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          if (last_q) begin
            chain_d  = base_q;
            active_d = 1'b0;
          end else begin
            // Both directions chain on plaintext ^ ciphertext.
            chain_d = in_q ^ out_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      blk_q    <= '0;
      in_q     <= '0;
      out_q    <= '0;
      base_q   <= '0;
      chain_q  <= '0;
      last_q   <= 1'b0;
      mode_q   <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      in_q     <= in_d;
      out_q    <= out_d;
      base_q   <= base_d;
      chain_q  <= chain_d;
      last_q   <= last_d;
      mode_q   <= mode_d;
      active_q <= active_d;
    end
  end

  assign in_ready  = reset && (state_q == S_IDLE);
  assign aes_start = (state_q == S_START);
  assign out_valid = (state_q == S_OUTPUT);
  assign busy      = (state_q != S_IDLE);
  assign aes_enc   = mode_q;
  assign aes_blk_o = blk_q;
  assign out_data  = out_q;
  assign out_last  = last_q && out_valid;

endmodule
